// File: rtl/aes_cipher_seq.sv
// AES-128/192/256 forward cipher, one round per clock, round keys from a combinational KeyExpansion.
// Latency: out_valid rises Nr cycles after the accepting edge; back-to-back accept on the output handshake edge.
// Backpressure: result held in DONE until out_ready; in_ready low during ROUND. Option: AES_ENC_CLEAR_ON_DONE_EN.

package aes_cipher_seq_pkg;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of the state sits at [127-8i -: 8]; byte i is row i%4, column i/4.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// Combinational AES key schedule: all Nr+1 round keys, round key 0 in the top 128 bits.
// Latency: none (pure logic from key).
// Backpressure: not applicable.
module KeyExpansion #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [Nk*32-1:0]      key,
    output logic [(Nr+1)*128-1:0] w
);
    import aes_cipher_seq_pkg::*;

    localparam int NW = 4 * (Nr + 1);

    logic [31:0] wd [0:NW-1];

    // Word recurrence of the schedule; rcon advances once per Nk words.
    always_comb begin
        logic [31:0] t;
        logic [7:0]  rc;
        t  = '0;
        rc = 8'h01;
        for (int i = 0; i < Nk; i++) wd[i] = key[Nk*32-1 - 32 * i -: 32];
        for (int i = Nk; i < NW; i++) begin
            t = wd[i-1];
            if (i % Nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-Nk] ^ t;
        end
    end

    // Pack words with word 0 most significant.
    always_comb begin
        w = '0;
        for (int i = 0; i < NW; i++) w[(Nr+1)*128-1 - 32 * i -: 32] = wd[i];
    end
endmodule

module aes_cipher_seq #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    input  logic [Nk*32-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out,
    output logic             busy
);
    import aes_cipher_seq_pkg::*;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [3:0] NR4 = 4'(Nr);

    fsm_t              fsm_q, fsm_d;
    logic [127:0]      state_q, state_d;
    logic [Nk*32-1:0]  key_q, key_d;
    logic [3:0]        rnd_q, rnd_d;
    logic [127:0]      dout_q, dout_d;

    logic [(Nr+1)*128-1:0] w;
    logic [127:0]          rk [0:Nr];
    logic [127:0]          sr, round_full, round_last;
    logic                  accept;

    KeyExpansion #(.Nk(Nk), .Nr(Nr)) u_key_exp (
        .key (key_q),
        .w   (w)
    );

    // Slice the schedule into addressable round keys.
    always_comb begin
        for (int r = 0; r <= Nr; r++) rk[r] = w[(Nr+1)*128-1 - 128 * r -: 128];
    end

    // One cipher round; the last round skips MixColumns.
    always_comb begin
        sr         = shift_rows(sub_bytes(state_q));
        round_full = mix_columns(sr) ^ rk[rnd_q];
        round_last = sr ^ rk[rnd_q];
    end

    assign in_ready  = !rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == ROUND);

`ifdef AES_ENC_CLEAR_ON_DONE_EN
    assign data_out = out_valid ? dout_q : '0;
`else
    assign data_out = dout_q;
`endif

    // Next-state: accept loads key and whitened state, ROUND iterates, DONE waits for out_ready.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (accept) begin
                    key_d   = key;
                    state_d = data_in ^ key[Nk*32-1 -: 128];
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end else if (fsm_q == DONE && out_ready) begin
                    fsm_d = IDLE;
`ifdef AES_ENC_CLEAR_ON_DONE_EN
                    state_d = '0;
                    key_d   = '0;
                    dout_d  = '0;
`endif
                end
            end
            ROUND: begin
                if (rnd_q == NR4) begin
                    state_d = round_last;
                    dout_d  = round_last;
                    fsm_d   = DONE;
                end else begin
                    state_d = round_full;
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers; reset discards any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            dout_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
        end
    end
endmodule
